program_loader_sequencer: RTL and testbench

//  Byte-command sequencer that owns the processor's external memory port and pause line.

---
 rtl/program_loader_sequencer_if.sv | 55 +++++
 rtl/program_loader_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_program_loader_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_sequencer_if.sv
// Serial byte stream and processor memory-port bundle
// for the program loader sequencer.
interface program_loader_sequencer_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        pause;
  logic        externalMemoryControl;
  logic [31:0] externalAddress;
  logic [31:0] externalData;
  logic [2:0]  externalReadMode;
  logic [2:0]  externalWriteMode;
  logic [31:0] externalDataOut;
  logic        busy;
  logic        error;

  modport master (
    input  rx_valid,
    input  rx_data,
    input  tx_ready,
    input  externalDataOut,
    output rx_ready,
    output tx_valid,
    output tx_data,
    output pause,
    output externalMemoryControl,
    output externalAddress,
    output externalData,
    output externalReadMode,
    output externalWriteMode,
    output busy,
    output error
  );

  modport slave (
    output rx_valid,
    output rx_data,
    output tx_ready,
    output externalDataOut,
    input  rx_ready,
    input  tx_valid,
    input  tx_data,
    input  pause,
    input  externalMemoryControl,
    input  externalAddress,
    input  externalData,
    input  externalReadMode,
    input  externalWriteMode,
    input  busy,
    input  error
  );
endinterface

// File: rtl/program_loader_sequencer.sv
// Byte-command sequencer: loads program words, dumps memory
// over serial, and starts/stops the processor.
module program_loader_sequencer #(
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int unsigned MAX_WORDS    = 16384,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  program_loader_sequencer_if.master bus
);

  localparam logic [2:0]  MODE_NONE = 3'd0;
  localparam logic [2:0]  MODE_WORD = 3'd2;
  localparam logic [7:0]  CMD_L     = 8'h4C;
  localparam logic [7:0]  CMD_D     = 8'h44;
  localparam logic [7:0]  CMD_R     = 8'h52;
  localparam logic [7:0]  CMD_P     = 8'h50;
  localparam logic [31:0] MAX_W     = 32'(MAX_WORDS);
  localparam logic [7:0]  LAT       = 8'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L_LEN,
    S_L_DATA,
    S_L_WRITE,
    S_D_ADDR,
    S_D_CNT,
    S_D_READ,
    S_D_SEND
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [23:0] shift_q;
  logic [31:0] remain_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [7:0]  lat_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        pause_q;
  logic        emc_q;
  logic        err_q;

  logic        rx_ready;
  logic        rx_fire;
  logic        tx_fire;
  logic        byte_last;
  logic        last_word;
  logic        rd_done;
  logic        len_bad;
  logic [31:0] word_in;
  logic [2:0]  rd_mode;
  logic [2:0]  wr_mode;
  logic        busy;

  assign rx_fire   = bus.rx_valid & rx_ready;
  assign tx_fire   = tx_valid_q & bus.tx_ready;
  assign byte_last = (cnt_q == 2'd3);
  assign last_word = (remain_q == 32'd1);
  assign rd_done   = (lat_q == LAT);
  assign word_in   = {shift_q, bus.rx_data};
  assign len_bad   = (word_in > MAX_W);

  assign bus.rx_ready              = rx_ready;
  assign bus.tx_valid              = tx_valid_q;
  assign bus.tx_data               = tx_data_q;
  assign bus.pause                 = pause_q;
  assign bus.externalMemoryControl = emc_q;
  assign bus.externalAddress       = addr_q;
  assign bus.externalData          = wdata_q;
  assign bus.externalReadMode      = rd_mode;
  assign bus.externalWriteMode     = wr_mode;
  assign bus.busy                  = busy;
  assign bus.error                 = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: byte fields advance on the 4th byte of each field
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (bus.rx_data == CMD_L)      state_d = S_L_LEN;
          else if (bus.rx_data == CMD_D) state_d = S_D_ADDR;
        end
      end
      S_L_LEN: begin
        if (rx_fire && byte_last) begin
          if (word_in == 32'd0 || len_bad) state_d = S_IDLE;
          else                             state_d = S_L_DATA;
        end
      end
      S_L_DATA: begin
        if (rx_fire && byte_last) state_d = S_L_WRITE;
      end
      S_L_WRITE: begin
        state_d = last_word ? S_IDLE : S_L_DATA;
      end
      S_D_ADDR: begin
        if (rx_fire && byte_last) state_d = S_D_CNT;
      end
      S_D_CNT: begin
        if (rx_fire && byte_last) begin
          state_d = (word_in == 32'd0) ? S_IDLE : S_D_READ;
        end
      end
      S_D_READ: begin
        if (rd_done) state_d = S_D_SEND;
      end
      S_D_SEND: begin
        if (tx_fire && byte_last) begin
          state_d = last_word ? S_IDLE : S_D_READ;
        end
      end
    endcase
  end

  // Per-state outputs: memory modes only in L_WRITE / D_READ
  always_comb begin
    rx_ready = 1'b0;
    rd_mode  = MODE_NONE;
    wr_mode  = MODE_NONE;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE,
      S_L_LEN,
      S_L_DATA,
      S_D_ADDR,
      S_D_CNT:   rx_ready = 1'b1;
      S_L_WRITE: wr_mode  = MODE_WORD;
      S_D_READ:  if (lat_q < LAT) rd_mode = MODE_WORD;
      S_D_SEND:  rx_ready = 1'b0;
    endcase
  end

  // Datapath: field assembly, address/count, tx byte, pause line
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      shift_q    <= 24'd0;
      remain_q   <= 32'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      lat_q      <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
      pause_q    <= 1'b1;
      emc_q      <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (rx_fire) shift_q <= word_in[23:0];
      if ((rx_fire && state_q != S_IDLE) || tx_fire) begin
        cnt_q <= cnt_q + 2'd1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (rx_fire) begin
            if (bus.rx_data == CMD_L || bus.rx_data == CMD_D ||
                bus.rx_data == CMD_P) begin
              pause_q <= 1'b1;
              emc_q   <= 1'b1;
            end else if (bus.rx_data == CMD_R) begin
              pause_q <= 1'b0;
              emc_q   <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_L_LEN: begin
          if (rx_fire && byte_last) begin
            if (len_bad) err_q <= 1'b1;
            remain_q <= word_in;
            addr_q   <= BASE_ADDR;
          end
        end
        S_L_DATA: begin
          if (rx_fire && byte_last) wdata_q <= word_in;
        end
        S_L_WRITE: begin
          remain_q <= remain_q - 32'd1;
          if (!last_word) addr_q <= addr_q + 32'd4;
        end
        S_D_ADDR: begin
          if (rx_fire && byte_last) addr_q <= word_in;
        end
        S_D_CNT: begin
          if (rx_fire && byte_last) begin
            remain_q <= word_in;
            lat_q    <= 8'd0;
          end
        end
        S_D_READ: begin
          if (rd_done) begin
            lat_q      <= 8'd0;
            rdata_q    <= bus.externalDataOut;
            tx_valid_q <= 1'b1;
            tx_data_q  <= bus.externalDataOut[31:24];
          end else begin
            lat_q <= lat_q + 8'd1;
          end
        end
        S_D_SEND: begin
          if (tx_fire) begin
            if (byte_last) begin
              tx_valid_q <= 1'b0;
              remain_q   <= remain_q - 32'd1;
              if (!last_word) addr_q <= addr_q + 32'd4;
            end else begin
              rdata_q   <= {rdata_q[23:0], 8'h00};
              tx_data_q <= rdata_q[23:16];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader_sequencer.sv
// Directed bench for program_loader_sequencer with a
// one-clock registered memory model.
module tb_program_loader_sequencer;
  localparam logic [2:0] NONE = 3'd0;
  localparam logic [2:0] WORD = 3'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  program_loader_sequencer_if bus();

  program_loader_sequencer #(
    .BASE_ADDR(32'd1024),
    .MAX_WORDS(16384),
    .READ_LATENCY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] wa [0:7];
  logic [31:0] wd [0:7];
  int   wr_cnt  = 0;
  int   both_cnt = 0;
  int   long_wr = 0;
  logic prev_wr = 1'b0;

  // Memory model plus write log and mode-sanity monitors
  always @(posedge clk) begin
    if (bus.externalWriteMode == WORD) begin
      mem[bus.externalAddress[11:2]] <= bus.externalData;
      if (wr_cnt < 8) begin
        wa[wr_cnt] <= bus.externalAddress;
        wd[wr_cnt] <= bus.externalData;
      end
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.externalReadMode == WORD) begin
      bus.externalDataOut <= mem[bus.externalAddress[11:2]];
    end
    if (bus.externalReadMode == WORD && bus.externalWriteMode == WORD) begin
      both_cnt <= both_cnt + 1;
    end
    if (prev_wr && bus.externalWriteMode == WORD) long_wr <= long_wr + 1;
    prev_wr <= (bus.externalWriteMode == WORD);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rx_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31 - 8 * k -: 8]);
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [7:0]  got;
    int          n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pause", 32'(bus.pause), 32'd1);
    check("rst_emc", 32'(bus.externalMemoryControl), 32'd1);
    check("rst_rmode", 32'(bus.externalReadMode), 32'(NONE));
    check("rst_wmode", 32'(bus.externalWriteMode), 32'(NONE));
    check("rst_txv", 32'(bus.tx_valid), 32'd0);
    check("rst_rxr", 32'(bus.rx_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_addr", bus.externalAddress, 32'd0);
    check("rst_err", 32'(bus.error), 32'd0);
    rst = 1'b0;

    send_byte(8'h4C);
    send_word(32'd2);
    send_word(32'hDEADBEEF);
    check("w0_rxr", 32'(bus.rx_ready), 32'd0);
    check("w0_mode", 32'(bus.externalWriteMode), 32'(WORD));
    check("w0_addr", bus.externalAddress, 32'd1024);
    check("w0_data", bus.externalData, 32'hDEADBEEF);
    send_word(32'h01234567);
    check("w1_addr", bus.externalAddress, 32'd1028);
    @(negedge clk);
    check("ld_busy", 32'(bus.busy), 32'd0);
    check("ld_wmode", 32'(bus.externalWriteMode), 32'(NONE));
    check("ld_pause", 32'(bus.pause), 32'd1);
    check("ld_wrcnt", 32'(wr_cnt), 32'd2);
    check("ld_wa0", wa[0], 32'd1024);
    check("ld_wd0", wd[0], 32'hDEADBEEF);
    check("ld_wa1", wa[1], 32'd1028);
    check("ld_wd1", wd[1], 32'h01234567);

    send_byte(8'h52);
    check("run_pause", 32'(bus.pause), 32'd0);
    check("run_emc", 32'(bus.externalMemoryControl), 32'd0);
    send_byte(8'h50);
    check("stop_pause", 32'(bus.pause), 32'd1);
    check("stop_emc", 32'(bus.externalMemoryControl), 32'd1);

    send_byte(8'h44);
    send_word(32'h00000400);
    send_word(32'd1);
    exp_w = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!bus.tx_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("tx_wait", 32'(n < 50), 32'd1);
      got = bus.tx_data;
      check("tx_byte", 32'(got), 32'(exp_w[31 - 8 * i -: 8]));
      if (i == 1) begin
        repeat (3) begin
          @(negedge clk);
          check("tx_hold", {23'd0, bus.tx_valid, bus.tx_data},
                {23'd0, 1'b1, got});
        end
      end
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
    end
    @(negedge clk);
    check("d_busy", 32'(bus.busy), 32'd0);
    check("d_txv", 32'(bus.tx_valid), 32'd0);
    check("rw_both", 32'(both_cnt), 32'd0);
    check("wr_len", 32'(long_wr), 32'd0);

    send_byte(8'h7A);
    check("bad_err", 32'(bus.error), 32'd1);
    check("bad_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("bad_pulse", 32'(bus.error), 32'd0);

    send_byte(8'h4C);
    send_word(32'h00004001);
    check("big_err", 32'(bus.error), 32'd1);
    check("big_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("big_wrcnt", 32'(wr_cnt), 32'd2);
    send_byte(8'h52);
    check("big_cmd", 32'(bus.pause), 32'd0);

    send_byte(8'h4C);
    send_word(32'd0);
    check("zero_busy", 32'(bus.busy), 32'd0);
    check("zero_err", 32'(bus.error), 32'd0);
    check("zero_pause", 32'(bus.pause), 32'd1);

    send_byte(8'h4C);
    send_word(32'd2);
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    @(negedge clk);
    check("mid_pause", 32'(bus.pause), 32'd1);
    check("mid_emc", 32'(bus.externalMemoryControl), 32'd1);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_rxr", 32'(bus.rx_ready), 32'd1);
    check("mid_addr", bus.externalAddress, 32'd0);
    check("mid_wmode", 32'(bus.externalWriteMode), 32'(NONE));
    rst = 1'b0;
    @(negedge clk);
    check("mid_wrcnt", 32'(wr_cnt), 32'd3);
    check("mid_wa", wa[2], 32'd1024);
    check("mid_wd", wd[2], 32'h11223344);
    check("mid_w1", mem[257], 32'h01234567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
